// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier scheduler.
package mult_pkg;

    localparam int unsigned MULT_W       = 16;
    localparam int unsigned NREQ_DEFAULT = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StLda,
        StLdb,
        StWait,
        StResp
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module rr_arbiter
    import mult_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEFAULT,
    localparam int unsigned IdxW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    // Scan from ptr_i upward; the first hit wins and later hits are masked.
    always_comb begin
        int unsigned cand;
        logic [IdxW-1:0] cand_idx;
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand     = (32'(ptr_i) + i) % NREQ;
            cand_idx = IdxW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o         = 1'b1;
                idx_o           = cand_idx;
                gnt_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one serial repeated-addition multiplier among NREQ requesters.
module mult_sched
    import mult_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEFAULT,
    localparam int unsigned W    = MULT_W,
    localparam int unsigned IdxW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [NREQ-1:0]   rsp_valid_o,
    input  logic [NREQ-1:0]   rsp_ready_i,
    output logic [W-1:0]      rsp_data_o,
    output logic              busy_o,
    output logic              mul_start_o,
    output logic [W-1:0]      mul_in_o,
    input  logic              mul_done_i,
    input  logic [W-1:0]      mul_out_i
);

    sched_state_t    state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] gidx_q, gidx_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    res_q, res_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IdxW-1:0] arb_idx;
    logic            arb_valid;
    logic [W-1:0]    cand_a, cand_b, cand_hi, cand_lo;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Operands of the candidate requester, ordered so the smaller one sets the iteration count.
    always_comb begin
        cand_a = req_a_i[arb_idx*W +: W];
        cand_b = req_b_i[arb_idx*W +: W];
        if (cand_a >= cand_b) begin
            cand_hi = cand_a;
            cand_lo = cand_b;
        end else begin
            cand_hi = cand_b;
            cand_lo = cand_a;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gidx_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_d       = res_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        mul_start_o = 1'b0;
        mul_in_o    = '0;
        busy_o      = (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    req_ready_o = arb_gnt;
                    gidx_d      = arb_idx;
                    opa_d       = cand_hi;
                    opb_d       = cand_lo;
                    // A zero count would make the multiplier spin 65536 times; answer directly.
                    if (cand_lo == '0) begin
                        res_d   = '0;
                        state_d = StResp;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                mul_start_o = 1'b1;
                state_d     = StLda;
            end
            StLda: begin
                mul_in_o = opa_q;
                state_d  = StLdb;
            end
            StLdb: begin
                mul_in_o = opb_q;
                state_d  = StWait;
            end
            StWait: begin
                if (mul_done_i) begin
                    res_d   = mul_out_i;
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid_o = NREQ'(1) << gidx_q;
                rsp_data_o  = res_q;
                if (rsp_ready_i[gidx_q]) begin
                    ptr_d   = (gidx_q == IdxW'(NREQ - 1)) ? '0 : gidx_q + IdxW'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched with a behavioural repeated-addition multiplier beside it.
module tb_mult_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [15:0] rsp_data, mul_in, mul_out;
    logic        busy, mul_start, mul_done;

    typedef struct {
        int          idx;
        logic [15:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   mstart_cnt = 0;
    int   rsp_cnt    = 0;

    mult_sched #(
        .NREQ (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy),
        .mul_start_o (mul_start),
        .mul_in_o    (mul_in),
        .mul_done_i  (mul_done),
        .mul_out_i   (mul_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: Start while idle, load A, load B, B add cycles, one-cycle Done.
    logic [2:0]  m_st;
    logic [15:0] m_a, m_cnt, m_prod;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st   <= 3'd0;
            m_a    <= '0;
            m_cnt  <= '0;
            m_prod <= '0;
        end else begin
            case (m_st)
                3'd0: if (mul_start) m_st <= 3'd1;
                3'd1: begin m_a <= mul_in; m_st <= 3'd2; end
                3'd2: begin m_cnt <= mul_in; m_prod <= '0; m_st <= 3'd3; end
                3'd3: begin
                    m_prod <= m_prod + m_a;
                    m_cnt  <= m_cnt - 16'd1;
                    if (m_cnt == 16'd1) m_st <= 3'd4;
                end
                default: m_st <= 3'd0;
            endcase
        end
    end
    assign mul_done = (m_st == 3'd4);
    assign mul_out  = m_prod;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Event counters observed by the stimulus process.
    initial forever begin
        @(negedge clk);
        if (mul_start) mstart_cnt++;
        if (rsp_valid != '0) rsp_cnt++;
    end

    // Monitor: latency, stability while held, and scoreboard pop on handshake.
    initial begin
        bit          in_rsp = 1'b0;
        int          first  = 0;
        logic [3:0]  hold_v = '0;
        logic [15:0] hold_d = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst || rsp_valid == '0) begin
                in_rsp = 1'b0;
            end else begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    first  = cyc;
                    hold_v = rsp_valid;
                    hold_d = rsp_data;
                    check("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
                end else begin
                    check("rsp_hold_valid", rsp_valid, hold_v);
                    check("rsp_hold_data", rsp_data, hold_d);
                end
                if ((rsp_valid & rsp_ready) != '0) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_port", rsp_valid, 64'(4'b0001 << e.idx));
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_latency", first - e.acc, e.lat);
                    end
                    in_rsp = 1'b0;
                end
            end
        end
    end

    // Present a request, wait for its accept pulse and record the expected response.
    task automatic accept(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] prod, input int lat);
        bit got = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        req_a[idx*16 +: 16] = a;
        req_b[idx*16 +: 16] = b;
        req_valid[idx]      = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = 1'b1;
                check("accept_grant", req_ready, 64'(4'b0001 << idx));
                e.idx  = idx;
                e.data = prod;
                e.acc  = cyc;
                e.lat  = lat;
                exp_q.push_back(e);
            end
        end
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic drop();
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, r0, k;
        int          order[5] = '{0, 1, 2, 3, 0};
        logic [15:0] ra[4]    = '{16'd2, 16'd9, 16'd11, 16'd6};
        logic [15:0] rb[4]    = '{16'd7, 16'd4, 16'd3, 16'd6};
        logic [15:0] rp[4]    = '{16'd14, 16'd36, 16'd33, 16'd36};
        int          rl[4]    = '{7, 9, 8, 11};

        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_busy", busy, 0);
        check("reset_mul_start", mul_start, 0);
        check("reset_mul_in", mul_in, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single request: 3*5, operands swapped so B=3.
        accept(0, 16'd3, 16'd5, 16'd15, 8);
        drop();
        @(negedge clk); check("t1_mul_start_c1", mul_start, 1);
        @(negedge clk); check("t1_mul_in_c2", mul_in, 5);
        @(negedge clk); check("t1_mul_in_c3", mul_in, 3);
        @(negedge clk); check("t1_mul_in_idle", mul_in, 0);
        wait_done(50);

        // Zero operand answers at once without touching the multiplier.
        m0 = mstart_cnt;
        accept(1, 16'd0, 16'd1234, 16'd0, 1);
        drop();
        wait_done(20);
        check("t2_no_mul_start", mstart_cnt - m0, 0);

        // Overflow wraps modulo 2^16.
        accept(2, 16'd300, 16'd300, 16'd24464, 305);
        drop();
        wait_done(400);

        // Backpressure on requester 3 while requester 0 waits.
        rsp_ready = '0;
        accept(3, 16'd4, 16'd5, 16'd20, 9);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_a[15:0] = 16'd1;
        req_b[15:0] = 16'd1;
        k = 0;
        while (k < 30 && !rsp_valid[3]) begin
            @(negedge clk);
            k++;
        end
        check("t4_rsp_seen", rsp_valid[3], 1);
        repeat (10) begin
            @(negedge clk);
            check("t4_hold_valid", rsp_valid, 4'b1000);
            check("t4_hold_data", rsp_data, 20);
            check("t4_no_accept", req_ready, 0);
            check("t4_ptr_held", dut.ptr_q, 3);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '1;
        wait_done(20);

        // Round robin with all four requesters continuously valid.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = ra[i];
            req_b[i*16 +: 16] = rb[i];
        end
        req_valid = '1;
        k = 0;
        for (int i = 0; i < 200 && k < 5; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                exp_t e;
                check("t5_rr_grant", req_ready, 64'(4'b0001 << order[k]));
                e.idx  = order[k];
                e.data = rp[order[k]];
                e.acc  = cyc;
                e.lat  = rl[order[k]];
                exp_q.push_back(e);
                k++;
            end
        end
        check("t5_rr_count", k, 5);
        drop();
        wait_done(50);

        // Reset while the multiplier is running.
        accept(1, 16'd300, 16'd300, 16'd24464, 305);
        drop();
        repeat (50) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_rst_req_ready", req_ready, 0);
        check("t6_rst_rsp_valid", rsp_valid, 0);
        check("t6_rst_rsp_data", rsp_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_mul_start", mul_start, 0);
        check("t6_rst_mul_in", mul_in, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        r0 = rsp_cnt;
        repeat (400) @(negedge clk);
        check("t6_no_rsp_after_rst", rsp_cnt - r0, 0);
        accept(2, 16'd7, 16'd8, 16'd56, 12);
        drop();
        wait_done(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
